// File: rtl/mult8_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
//   OP_W   : operand width, fixed by the ripple-carry adder
//   PROD_W : product width
//   CNT_W  : iteration counter width (counts OP_W iterations)
//   mult_state_t : controller states
package mult8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter value at which the final iteration is performed.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

endpackage

// File: rtl/shift_add_mult8_rca8.sv
// 8-bit ripple-carry adder: a chain of full adders, carry rippling from
// bit 0 to bit 7.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : low 8 bits of a + b + cin
//   cout : carry out of bit 7
module rca8
  import mult8_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  logic [OP_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < OP_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[OP_W];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around the 8-bit
// ripple-carry adder. One iteration per clock; the product {acc, mq} is
// ready 8 cycles after the operands are accepted.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, clears every register
//   in_valid  : operand pair (a, b) valid
//   in_ready  : block can accept operands (IDLE and not in reset)
//   a, b      : multiplicand and multiplier, unsigned
//   out_valid : product valid (DONE)
//   out_ready : sink accepts product
//   product   : a * b
//   busy      : operation in progress (CALC or DONE)
module shift_add_mult8
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  mult_state_t       state, state_nxt;
  logic [OP_W-1:0]   mcand;
  logic [OP_W-1:0]   acc;
  logic [OP_W-1:0]   mq;
  logic [CNT_W-1:0]  cnt;

  logic [OP_W-1:0]   add_sum;
  logic              add_cout;
  logic              accept;

  // One shift-and-add step: the low multiplier bit selects whether the
  // adder result (with its carry as the 9th bit) or the unchanged
  // accumulator is shifted down into {acc, mq}.
  function automatic logic [PROD_W-1:0] shift_step(
    input logic              use_sum,
    input logic              carry,
    input logic [OP_W-1:0]   sum_v,
    input logic [OP_W-1:0]   acc_v,
    input logic [OP_W-1:0]   mq_v
  );
    if (use_sum)
      return {carry, sum_v, mq_v[OP_W-1:1]};
    else
      return {1'b0, acc_v, mq_v[OP_W-1:1]};
  endfunction

  rca8 u_rca8 (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = {acc, mq};
  assign accept    = in_valid && in_ready;

  // ---- controller state register ----
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)          state_nxt = CALC;
      CALC: if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: if (out_ready)       state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // ---- datapath: operand load, iterate, hold ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          {acc, mq} <= shift_step(mq[0], add_cout, add_sum, acc, mq);
          cnt       <= cnt + CNT_W'(1);
        end
        default: ;  // DONE holds the product until the sink takes it
      endcase
    end
  end

endmodule

// File: doc/shift_add_mult8.md
# shift_add_mult8

Sequential 8×8 unsigned shift-and-add multiplier. It is the control and register stage wrapped around the team's 8-bit ripple-carry adder. Each cycle it drives the adder's operands and consumes the adder's sum and carry-out, producing a 16-bit product after 8 iterations. Operands enter and the product leaves through valid/ready handshakes, so the block sits between an operand source and a result sink.

## Interface
- No parameters. Operand width is fixed at 8 by the adder; product width is 16.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  the operand pair is valid.
- `in_ready`  out  1  block accepts operands; high only in IDLE with `rst_n` high.
- `a`  in  8  multiplicand, unsigned.
- `b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  the sink accepts `product`.
- `product`  out  16  the product a×b.
- `busy`  out  1  high in CALC and DONE.

## Operation
- Registers:
  - `mcand` (8 bits)
  - `acc` (8 bits)
  - `mq` (8 bits)
  - `cnt` (3 bits)
  - `state`
- States are IDLE, CALC and DONE.
- **IDLE.** On a rising edge with `in_valid` and `in_ready` both high:
  - `mcand` ← `a`, `mq` ← `b`, `acc` ← 0, `cnt` ← 0.
  - `state` ← CALC.
- **CALC.** The adder inputs are `acc`, `mcand` and cin=0. Each edge:
  - If `mq[0]` = 1, {`acc`, `mq`} ← {cout, sum, `mq[7:1]`}.
  - If `mq[0]` = 0, {`acc`, `mq`} ← {1'b0, `acc`, `mq[7:1]`}.
  - `cnt` ← `cnt` + 1.
  - When `cnt` = 7, the edge performs the final iteration and sets `state` ← DONE.
- **DONE.** `out_valid` = 1 and `product` = {`acc`, `mq`}.
  - On an edge with `out_ready` = 1, `state` ← IDLE.
- Arithmetic rules:
  - The adder carry-out is the only 9th bit kept.
  - No overflow is possible, because 255×255 = 65025 fits in 16 bits.
- Outputs are decoded from `state`:
  - `in_ready` = (`state` == IDLE) && `rst_n`.
  - `out_valid` = (`state` == DONE).
  - `busy` = (`state` != IDLE).

## Timing
- Reset: on any edge with `rst_n` = 0, every register is forced to 0.
  - `state` = IDLE, so `out_valid` = 0, `busy` = 0 and `product` = 0x0000.
  - `in_ready` is 0 while `rst_n` is low and 1 in the cycle after release.
- Latency: with the accept edge as E0, iterations occur at E1..E8. `out_valid` goes high after E8, which is 8 cycles after acceptance.
- Throughput: at most one operation per 10 cycles (accept, 8 iterations, 1 output cycle). There is no back-to-back accept.
  - `in_ready` returns high in the cycle after the output handshake edge.
- Handshake rules:
  - `product` holds stable while `out_valid` = 1 and `out_ready` = 0, for any number of cycles.
  - If `out_ready` is held high, `out_valid` is a one-cycle pulse.
  - `out_ready` outside DONE has no effect.
  - `in_valid` outside IDLE is ignored.
  - Changes to `a` or `b` after the accept edge do not affect the result.
- Reset mid-operation: `rst_n` low during CALC or DONE aborts the operation. No `out_valid` is produced for it, and the next cycle is IDLE.
- The adder path is a combinational ripple through 8 full adders. It must close timing within one `clk` period from the `acc`/`mcand` registers back to `acc`.

## Structure
- Package `mult8_pkg`:
  - `OP_W` = 8, `PROD_W` = 16, `CNT_W` = 3.
  - enum `mult_state_t` {IDLE, CALC, DONE}.
- Sub-module: a single instance of the existing 8-bit ripple-carry adder (ports a, b, cin, sum, cout) with cin tied to 0. No other sub-modules.
- The FSM, counter and shift register live in `shift_add_mult8`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles → `out_valid` = 0, `busy` = 0, `product` = 0x0000, `in_ready` = 0. After release, `in_ready` = 1.
- **Basic product:** a = 13, b = 11 accepted at E0 → `out_valid` rises after E8 with `product` = 0x008F (143). With `out_ready` = 1 it drops after E9.
- **Carry path:** a = 255, b = 255 → `product` = 0xFE01. Also a = 0, b = 200 → 0x0000, and a = 1, b = 255 → 0x00FF.
- **Backpressure:** a = 200, b = 3 with `out_ready` = 0 for 5 cycles → `product` stays 0x0258 and `out_valid` stays 1. The handshake completes on the cycle `out_ready` is raised.
- **Ignored input:** `in_valid` = 1 with new a/b every cycle during CALC → the result still equals the accepted operands, and only one output is produced.
- **Abort:** `rst_n` = 0 at E4 of CALC → no `out_valid`, `state` is IDLE. The next operation, a = 7, b = 9, yields 0x003F.
